vdec_hs_crc_sched: RTL
======================

VDEC_HS_CRC_SCHED -- requirements
Module: vdec_hs_crc_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of CRC requesters; legal range 2..4.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 31, watchdog limit in clk cycles.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-005 SHALL have port req_valid  input  NREQ  per-requester check request, held until accepted.
REQ-006 SHALL have port req_ready  output  NREQ  one-hot accept pulse; transfer when valid and ready are both 1.
REQ-007 SHALL have port req_info_bits  input  NREQ*21  info field per requester; slice i = [21*i+20:21*i], LSB sent first.
REQ-008 SHALL have port req_crc_bits  input  NREQ*16  expected CRC per requester; slice i = [16*i+15:16*i].
REQ-009 SHALL have port req_info_len  input  NREQ*5  info length per requester; slice i = [5*i+4:5*i].
REQ-010 SHALL have port rsp_valid  output  1  one-cycle result pulse; there is no backpressure.
REQ-011 SHALL have port rsp_id  output  2  index of the requester the result belongs to.
REQ-012 SHALL have port rsp_match  output  1  CRC match result.
REQ-013 SHALL have port rsp_err  output  1  request rejected or timed out.
REQ-014 SHALL have ports eng_start  output  1, eng_info_bits  output  21, eng_crc_bits  output  16, eng_info_len  output  5, which drive the serial CRC engine.
REQ-015 SHALL have ports eng_busy  input  1, eng_done  input  1, eng_crc_match  input  1, which are returned by the serial CRC engine.

Function
REQ-016 SHALL implement the FSM IDLE -> START -> WAIT -> RESP -> IDLE, plus the path IDLE -> RESP for rejected requests.
REQ-017 In IDLE with any req_valid set, SHALL grant by round-robin from the pointer, pulse req_ready for the granted requester only, and latch its info, crc and len into registers.
REQ-018 SHALL update the round-robin pointer on each grant to granted+1, modulo NREQ; the pointer resets to 0.
REQ-019 SHALL reject a latched length of 0 or greater than 21: go directly to RESP with rsp_err=1 and rsp_match=0, and never assert eng_start.
REQ-020 In START, SHALL pulse eng_start for exactly one cycle, only when eng_busy=0; otherwise SHALL remain in START.
REQ-021 SHALL hold eng_info_bits, eng_crc_bits and eng_info_len stable from START until leaving WAIT, because the engine compares crc_bits at the end of the run.
REQ-022 In WAIT, on eng_done=1, SHALL capture eng_crc_match into rsp_match, set rsp_err=0, and go to RESP.
REQ-023 In RESP, SHALL assert rsp_valid for one cycle with rsp_id set to the granted index, then return to IDLE.
REQ-024 Latency: with accept at cycle T and valid length L, eng_start SHALL assert at T+1, eng_done SHALL occur at T+2+L, and rsp_valid SHALL assert at T+3+L.
REQ-025 For a rejected length accepted at cycle T, rsp_valid SHALL assert at T+1.
REQ-026 SHALL grant at most one request per pass through IDLE; there SHALL be no grant during START, WAIT or RESP.
REQ-027 SHALL ignore a stray eng_done received outside WAIT.
REQ-028 SHALL have a minimum spacing of 4+L cycles between back-to-back grants.

Reset
REQ-029 SHALL return all state asynchronously to reset values when rst_n=0: FSM=IDLE, pointer=0, latched fields=0.
REQ-030 Reset values SHALL be: req_ready=0, rsp_valid=0, rsp_id=0, rsp_match=0, rsp_err=0, eng_start=0, eng_info_bits=0, eng_crc_bits=0, eng_info_len=0.
REQ-031 Reset mid-operation SHALL abandon the run and produce no rsp_valid for it; the engine is reset by the same rst_n.

Configuration
REQ-032 SHALL compile in a watchdog when macro VDEC_HS_CRC_SCHED_TIMEOUT_EN is defined.
REQ-033 With the watchdog, a WAIT cycle counter SHALL clear on entry to WAIT; when it reaches TIMEOUT_CYC without eng_done, the FSM SHALL go to RESP with rsp_err=1 and rsp_match=0.
REQ-034 Without the macro, WAIT SHALL last until eng_done with no counter present, and rsp_err SHALL be set only by length rejection.

Structure
REQ-035 SHALL place FSM state encodings, info width 21, CRC width 16, length width 5 and maximum length 21 in shared package vdec_hs_pkg.
REQ-036 SHALL implement the round-robin grant as one sub-module, vdec_hs_rr_arb, which takes req vector and pointer and returns a one-hot grant and index.
REQ-037 SHALL NOT instantiate the serial CRC engine inside this block; the engine is connected at the parent level.

Verification
REQ-038 Requester 0 valid, len=21, correct CRC -> one req_ready[0] pulse, eng_start at T+1, rsp_valid at T+24 with id=0, match=1, err=0.
REQ-039 Requester 2, len=6, corrupted crc_bits bit 0 -> rsp_valid at T+9 with id=2, match=0, err=0.
REQ-040 All four requesters valid continuously -> grants occur in order 0,1,2,3,0, each responded before the next grant.
REQ-041 Requester 1, len=0 and then len=22 -> rsp_valid at T+1, err=1, match=0, and no eng_start.
REQ-042 With VDEC_HS_CRC_SCHED_TIMEOUT_EN defined and eng_done tied low -> rsp_valid with err=1, 32 cycles after WAIT entry.
REQ-043 rst_n pulsed low during WAIT -> all outputs 0 immediately, no rsp_valid; the next request is served from requester 0.

Source files
------------

// File: rtl/vdec_hs_pkg.sv
// Shared types and widths for the HS CRC check scheduler.
// State encodings, field widths and the length legality rule.
package vdec_hs_pkg;

    localparam int INFO_W  = 21;
    localparam int CRC_W   = 16;
    localparam int LEN_W   = 5;
    localparam int MAX_LEN = 21;
    localparam int ID_W    = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    function automatic logic len_ok(input logic [LEN_W-1:0] len);
        return (len != '0) && (len <= LEN_W'(MAX_LEN));
    endfunction

endpackage

// File: rtl/vdec_hs_rr_arb.sv
// Round-robin grant: first requester at or after ptr wins.
// Returns one-hot grant, its index, and an any-request flag.
module vdec_hs_rr_arb
    import vdec_hs_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] idx,
    output logic            hit
);

    logic [2:0] cand;

    // Scan from the pointer, wrapping at NREQ, and stop at the first hit.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        hit  = 1'b0;
        cand = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr} + 3'(k);
            if (cand >= 3'(NREQ)) begin
                cand = cand - 3'(NREQ);
            end
            if (!hit && req[cand[ID_W-1:0]]) begin
                hit                  = 1'b1;
                idx                  = cand[ID_W-1:0];
                gnt[cand[ID_W-1:0]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vdec_hs_crc_sched.sv
// Schedules CRC checks from NREQ requesters onto one serial engine.
// Optional WAIT watchdog: define VDEC_HS_CRC_SCHED_TIMEOUT_EN.
module vdec_hs_crc_sched
    import vdec_hs_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int TIMEOUT_CYC = 31
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*INFO_W-1:0]  req_info_bits,
    input  logic [NREQ*CRC_W-1:0]   req_crc_bits,
    input  logic [NREQ*LEN_W-1:0]   req_info_len,
    output logic                    rsp_valid,
    output logic [ID_W-1:0]         rsp_id,
    output logic                    rsp_match,
    output logic                    rsp_err,
    output logic                    eng_start,
    output logic [INFO_W-1:0]       eng_info_bits,
    output logic [CRC_W-1:0]        eng_crc_bits,
    output logic [LEN_W-1:0]        eng_info_len,
    input  logic                    eng_busy,
    input  logic                    eng_done,
    input  logic                    eng_crc_match
);

    state_t             state_q;
    state_t             state_d;
    logic [ID_W-1:0]    ptr_q;
    logic [NREQ-1:0]    gnt;
    logic [ID_W-1:0]    gidx;
    logic               hit;
    logic               grant;
    logic               wd_hit;
    logic [INFO_W-1:0]  sel_info;
    logic [CRC_W-1:0]   sel_crc;
    logic [LEN_W-1:0]   sel_len;
    logic [INFO_W-1:0]  info_q;
    logic [CRC_W-1:0]   crc_q;
    logic [LEN_W-1:0]   len_q;
    logic [ID_W-1:0]    id_q;
    logic               match_q;
    logic               err_q;

    vdec_hs_rr_arb #(
        .NREQ (NREQ)
    ) u_arb (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (gnt),
        .idx (gidx),
        .hit (hit)
    );

    assign grant     = (state_q == ST_IDLE) && hit;
    assign req_ready = (grant && rst_n) ? gnt : '0;

    // Route the granted requester's fields to the latch inputs.
    always_comb begin
        sel_info = '0;
        sel_crc  = '0;
        sel_len  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_info = req_info_bits[i*INFO_W +: INFO_W];
                sel_crc  = req_crc_bits[i*CRC_W +: CRC_W];
                sel_len  = req_info_len[i*LEN_W +: LEN_W];
            end
        end
    end

`ifdef VDEC_HS_CRC_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] wd_q;

    assign wd_hit = (state_q == ST_WAIT) && (wd_q == CNT_W'(TIMEOUT_CYC));

    // Count WAIT cycles; cleared whenever the FSM is outside WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q <= '0;
        end else if (state_q != ST_WAIT) begin
            wd_q <= '0;
        end else if (!wd_hit) begin
            wd_q <= wd_q + CNT_W'(1);
        end
    end
`else
    assign wd_hit = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the single-cycle start and response strobes.
    always_comb begin
        state_d   = state_q;
        eng_start = 1'b0;
        rsp_valid = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (hit) begin
                    state_d = len_ok(sel_len) ? ST_START : ST_RESP;
                end
            end
            ST_START: begin
                if (!eng_busy) begin
                    eng_start = 1'b1;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (eng_done || wd_hit) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Round-robin pointer moves past each granted requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (grant) begin
            ptr_q <= (gidx == ID_W'(NREQ - 1)) ? '0 : gidx + ID_W'(1);
        end
    end

    // Latch the request on grant; record the outcome in WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            info_q  <= '0;
            crc_q   <= '0;
            len_q   <= '0;
            id_q    <= '0;
            match_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (grant) begin
            info_q  <= sel_info;
            crc_q   <= sel_crc;
            len_q   <= sel_len;
            id_q    <= gidx;
            match_q <= 1'b0;
            err_q   <= !len_ok(sel_len);
        end else if (state_q == ST_WAIT) begin
            if (eng_done) begin
                match_q <= eng_crc_match;
                err_q   <= 1'b0;
            end else if (wd_hit) begin
                match_q <= 1'b0;
                err_q   <= 1'b1;
            end
        end
    end

    assign eng_info_bits = info_q;
    assign eng_crc_bits  = crc_q;
    assign eng_info_len  = len_q;
    assign rsp_id        = id_q;
    assign rsp_match     = match_q;
    assign rsp_err       = err_q;

endmodule
